// File: rtl/cam_fill_ctrl.sv
// cam_fill_ctrl: miss-handling and fill controller in front of a CAM cache.
// Looks tags up, refills misses from backing memory into a victim entry, and sequences full flushes.
module cam_fill_ctrl #(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic                flush,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [TAG_SZ-1:0]   req_tag,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [BITS-1:0]     rsp_data,
   output logic                rsp_hit,
   output logic                busy,
   output logic                cam_read,
   output logic [TAG_SZ-1:0]   cam_check_tag,
   input  logic                cam_found,
   input  logic [BITS-1:0]     cam_data,
   output logic                cam_write_,
   output logic [ADDR_LEFT:0]  cam_w_addr,
   output logic [BITS-1:0]     cam_wdata,
   output logic [TAG_SZ-1:0]   cam_new_tag,
   output logic                cam_new_valid,
   output logic                mem_req,
   output logic [TAG_SZ-1:0]   mem_tag,
   input  logic                mem_ack,
   input  logic [BITS-1:0]     mem_rdata
);
   typedef enum logic [2:0] {IDLE, LOOK, CMP, MREQ, FILL, RESP, FLUSH} state_t;
   localparam logic [ADDR_LEFT:0] LAST = (ADDR_LEFT + 1)'(WORDS - 1);
   state_t              state, nxt;
   logic [TAG_SZ-1:0]   tag_q;
   logic [BITS-1:0]     data_q;
   logic                hit_q;
   logic [WORDS-1:0]    vmap;
   logic [ADDR_LEFT:0]  rr_ptr, cnt, victim;
   logic                full;
   always_ff @(posedge clk or negedge rst_)
      if (!rst_) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = flush ? FLUSH : req_valid ? LOOK : IDLE;
         LOOK:    nxt = CMP;
         CMP:     nxt = cam_found ? RESP : MREQ;
         MREQ:    nxt = mem_ack ? FILL : MREQ;
         FILL:    nxt = RESP;
         RESP:    nxt = rsp_ready ? IDLE : RESP;
         FLUSH:   nxt = cnt == LAST ? IDLE : FLUSH;
         default: nxt = IDLE;
      endcase
   end
   // Lowest-index invalid entry wins; round-robin only once every entry is valid.
   always_comb begin
      victim = rr_ptr;
      for (int i = WORDS - 1; i >= 0; i--)
         if (!vmap[i]) victim = i[ADDR_LEFT:0];
   end
   assign full = &vmap;
   always_ff @(posedge clk or negedge rst_)
      if (!rst_) begin
         tag_q  <= '0;
         data_q <= '0;
         hit_q  <= 1'b0;
         vmap   <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (state == IDLE && !flush && req_valid) tag_q <= req_tag;
         if (state == IDLE) cnt <= '0;
         else if (state == FLUSH) cnt <= cnt + 1'b1;
         if (state == CMP && cam_found) begin
            data_q <= cam_data;
            hit_q  <= 1'b1;
         end
         if (state == MREQ && mem_ack) data_q <= mem_rdata;
         if (state == FILL) begin
            vmap[victim] <= 1'b1;
            hit_q        <= 1'b0;
            if (full) rr_ptr <= rr_ptr == LAST ? '0 : rr_ptr + 1'b1;
         end
         if (state == FLUSH && cnt == LAST) begin
            vmap   <= '0;
            rr_ptr <= '0;
         end
      end
   always_comb begin
      req_ready     = state == IDLE && !flush;
      busy          = state != IDLE;
      cam_read      = state == LOOK || state == CMP;
      cam_check_tag = (state == LOOK || state == CMP) ? tag_q : '0;
      cam_write_    = !(state == FILL || state == FLUSH);
      cam_w_addr    = state == FILL ? victim : state == FLUSH ? cnt : '0;
      cam_wdata     = state == FILL ? data_q : '0;
      cam_new_tag   = state == FILL ? tag_q : '0;
      cam_new_valid = state == FILL;
      mem_req       = state == MREQ;
      mem_tag       = state == MREQ ? tag_q : '0;
      rsp_valid     = state == RESP;
      rsp_data      = state == RESP ? data_q : '0;
      rsp_hit       = state == RESP && hit_q;
   end
endmodule

// File: tb/tb_cam_fill_ctrl.sv
// tb_cam_fill_ctrl: randomized bench for cam_fill_ctrl against a transaction-level cache model
// that predicts a full per-cycle output timeline for every request and flush.
module tb_cam_fill_ctrl;
   localparam int WORDS = 8;
   logic       clk = 1'b0, rst_ = 1'b0, flush = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
   logic       cam_found = 1'b0, mem_ack = 1'b0;
   logic [7:0] req_tag = '0, cam_data = '0, mem_rdata = '0;
   logic       req_ready, rsp_valid, rsp_hit, busy, cam_read, cam_write_, cam_new_valid, mem_req;
   logic [7:0] rsp_data, cam_check_tag, cam_wdata, cam_new_tag, mem_tag;
   logic [2:0] cam_w_addr;
   typedef struct packed {
      logic       req_ready;
      logic       rsp_valid;
      logic [7:0] rsp_data;
      logic       rsp_hit;
      logic       busy;
      logic       cam_read;
      logic [7:0] cam_check_tag;
      logic       cam_write_;
      logic [2:0] cam_w_addr;
      logic [7:0] cam_wdata;
      logic [7:0] cam_new_tag;
      logic       cam_new_valid;
      logic       mem_req;
      logic [7:0] mem_tag;
   } outs_t;
   outs_t      act, e_cmp;
   outs_t      exp_q[$];
   int         checks = 0, errors = 0, flush_writes = 0;
   logic [2:0] wlog[$];
   logic [7:0] last_data = '0;
   logic       last_hit = 1'b0;
   logic       m_valid[WORDS];
   logic [7:0] m_tag[WORDS], m_data[WORDS];
   int         m_rr;
   int         fill_addrs[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
   always #5 clk = ~clk;
   cam_fill_ctrl dut (
      .clk(clk), .rst_(rst_), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_hit(rsp_hit), .busy(busy), .cam_read(cam_read), .cam_check_tag(cam_check_tag),
      .cam_found(cam_found), .cam_data(cam_data), .cam_write_(cam_write_),
      .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata), .cam_new_tag(cam_new_tag),
      .cam_new_valid(cam_new_valid), .mem_req(mem_req), .mem_tag(mem_tag),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );
   assign act = {req_ready, rsp_valid, rsp_data, rsp_hit, busy, cam_read, cam_check_tag,
                 cam_write_, cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid, mem_req, mem_tag};
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_cmp = exp_q.pop_front();
         checks++;
         if (act !== e_cmp) begin
            errors++;
            $display("FAIL outputs at %0t: got %h expected %h", $time, act, e_cmp);
         end
      end
      if (!cam_write_ && cam_new_valid) wlog.push_back(cam_w_addr);
      if (!cam_write_ && !cam_new_valid) flush_writes++;
      if (rsp_valid && rsp_ready) begin
         last_data = rsp_data;
         last_hit  = rsp_hit;
      end
   end
   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask
   function automatic outs_t idle_e(input logic fl);
      outs_t e;
      e = '0;
      e.cam_write_ = 1'b1;
      e.req_ready = !fl;
      return e;
   endfunction
   function automatic outs_t busy_e();
      outs_t e;
      e = '0;
      e.cam_write_ = 1'b1;
      e.busy = 1'b1;
      return e;
   endfunction
   function automatic int lookup(input logic [7:0] t);
      for (int i = 0; i < WORDS; i++)
         if (m_valid[i] && m_tag[i] == t) return i;
      return -1;
   endfunction
   function automatic void model_clear();
      for (int i = 0; i < WORDS; i++) m_valid[i] = 1'b0;
      m_rr = 0;
   endfunction
   task automatic tick(input outs_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic noise();
      req_valid = 1'($urandom);
      req_tag   = 8'($urandom);
      flush     = 1'($urandom);
      mem_ack   = 1'($urandom);
      mem_rdata = 8'($urandom);
      cam_found = 1'($urandom);
      cam_data  = 8'($urandom);
      rsp_ready = 1'($urandom);
   endtask
   task automatic idle();
      noise();
      req_valid = 1'b0;
      flush = 1'b0;
      tick(idle_e(1'b0));
   endtask
   task automatic txn(input logic [7:0] t, input int waits, input int bp, input logic [7:0] md);
      int idx, v;
      logic hit;
      logic [7:0] d;
      outs_t e;
      idx = lookup(t);
      hit = idx >= 0;
      d = hit ? m_data[idx] : md;
      noise(); req_valid = 1'b1; req_tag = t; flush = 1'b0;
      tick(idle_e(1'b0));
      e = busy_e(); e.cam_read = 1'b1; e.cam_check_tag = t;
      noise();
      tick(e);
      noise(); cam_found = hit; if (hit) cam_data = d;
      tick(e);
      if (!hit) begin
         e = busy_e(); e.mem_req = 1'b1; e.mem_tag = t;
         for (int i = 0; i < waits; i++) begin
            noise(); mem_ack = 1'b0;
            tick(e);
         end
         noise(); mem_ack = 1'b1; mem_rdata = d;
         tick(e);
         v = -1;
         for (int i = 0; i < WORDS; i++) if (!m_valid[i] && v < 0) v = i;
         if (v < 0) begin
            v = m_rr;
            m_rr = (m_rr + 1) % WORDS;
         end
         m_valid[v] = 1'b1; m_tag[v] = t; m_data[v] = d;
         e = busy_e(); e.cam_write_ = 1'b0; e.cam_w_addr = 3'(v);
         e.cam_wdata = d; e.cam_new_tag = t; e.cam_new_valid = 1'b1;
         noise();
         tick(e);
      end
      e = busy_e(); e.rsp_valid = 1'b1; e.rsp_data = d; e.rsp_hit = hit;
      for (int i = 0; i < bp; i++) begin
         noise(); rsp_ready = 1'b0;
         tick(e);
      end
      noise(); rsp_ready = 1'b1;
      tick(e);
   endtask
   task automatic flush_op(input logic rv);
      outs_t e;
      noise(); flush = 1'b1; req_valid = rv;
      tick(idle_e(1'b1));
      for (int i = 0; i < WORDS; i++) begin
         noise(); req_valid = 1'b1;
         e = busy_e(); e.cam_write_ = 1'b0; e.cam_w_addr = 3'(i);
         tick(e);
      end
      model_clear();
   endtask
   task automatic reset_mid();
      outs_t e;
      noise(); req_valid = 1'b1; req_tag = 8'hEE; flush = 1'b0;
      tick(idle_e(1'b0));
      e = busy_e(); e.cam_read = 1'b1; e.cam_check_tag = 8'hEE;
      noise();
      tick(e);
      noise(); cam_found = 1'b0;
      tick(e);
      e = busy_e(); e.mem_req = 1'b1; e.mem_tag = 8'hEE;
      noise(); mem_ack = 1'b0;
      tick(e);
      noise(); mem_ack = 1'b0; flush = 1'b0;
      #2 rst_ = 1'b0;
      tick(idle_e(1'b0));
      noise(); flush = 1'b0;
      tick(idle_e(1'b0));
      rst_ = 1'b1;
      noise(); req_valid = 1'b0; flush = 1'b0;
      tick(idle_e(1'b0));
      model_clear();
   endtask
   initial begin
      int n, fw;
      model_clear();
      @(posedge clk);
      #1;
      tick(idle_e(1'b0));
      tick(idle_e(1'b0));
      rst_ = 1'b1;
      tick(idle_e(1'b0));
      txn(8'h3C, 4, 0, 8'hA5);
      chk("miss fill count", wlog.size(), 1);
      chk("miss fill addr", int'(wlog[0]), 0);
      chk("miss rsp_data", last_data, 8'hA5);
      chk("miss rsp_hit", last_hit, 0);
      idle();
      txn(8'h3C, 0, 0, 8'h00);
      chk("hit rsp_data", last_data, 8'hA5);
      chk("hit rsp_hit", last_hit, 1);
      flush_writes = 0;
      flush_op(1'b1);
      chk("flush write count", flush_writes, WORDS);
      wlog.delete();
      for (int i = 0; i < 11; i++) txn(8'(8'h10 + i), $urandom_range(0, 3), 0, 8'(8'h80 + i));
      chk("replacement fill count", wlog.size(), 11);
      for (int i = 0; i < 11; i++)
         if (i < wlog.size()) chk($sformatf("replacement fill %0d addr", i), int'(wlog[i]), fill_addrs[i]);
      txn(8'h1A, 0, 5, 8'h00);
      chk("backpressure rsp_data", last_data, 8'h8A);
      chk("backpressure rsp_hit", last_hit, 1);
      repeat (300) begin
         if ($urandom_range(0, 24) == 0) flush_op(1'($urandom));
         else txn(8'($urandom_range(0, 15)), $urandom_range(0, 5),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 8'($urandom));
         repeat ($urandom_range(0, 2)) idle();
      end
      n = wlog.size();
      fw = flush_writes;
      reset_mid();
      chk("no fill write across reset", wlog.size(), n);
      chk("no flush write across reset", flush_writes, fw);
      txn(8'h77, 1, 0, 8'h5A);
      chk("post-reset fill addr", int'(wlog[wlog.size() - 1]), 0);
      chk("post-reset rsp_data", last_data, 8'h5A);
      idle();
      chk("expectations drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cam_fill_ctrl.md
# cam_fill_ctrl

Miss-handling and fill controller that sits in front of the CAM cache and drives its lookup and write ports. It accepts tag lookup requests and checks the CAM. On a hit it returns the cached data. On a miss it fetches the data from backing memory, writes it into a victim CAM entry, and returns the fetched data. It also sequences a full-cache flush.

## Interface
- WORDS, 8, number of CAM entries
- BITS, 8, data width
- TAG_SZ, 8, tag width
- ADDR_LEFT, $clog2(WORDS)-1, MSB of a CAM entry address
- clk  in  1  system clock
- rst_  in  1  reset; asynchronous, active-low
- flush  in  1  single-cycle flush command
- req_valid  in  1  lookup request valid
- req_ready  out  1  controller can accept a request
- req_tag  in  TAG_SZ  tag to look up
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  BITS  returned data
- rsp_hit  out  1  1 = CAM hit, 0 = filled from memory
- busy  out  1  state != IDLE
- cam_read  out  1  CAM read strobe
- cam_check_tag  out  TAG_SZ  tag presented to CAM
- cam_found  in  1  CAM match flag
- cam_data  in  BITS  CAM read data
- cam_write_  out  1  CAM write strobe, active-low
- cam_w_addr  out  ADDR_LEFT+1  CAM write address
- cam_wdata  out  BITS  CAM write data
- cam_new_tag  out  TAG_SZ  tag written
- cam_new_valid  out  1  valid bit written
- mem_req  out  1  backing-memory read request
- mem_tag  out  TAG_SZ  requested tag
- mem_ack  in  1  memory data valid, single-cycle pulse
- mem_rdata  in  BITS  memory data

## Operation
- State machine: IDLE, LOOK, CMP, MREQ, FILL, RESP, FLUSH.
- Internal state:
  - valid bitmap vmap[WORDS-1:0], a shadow of the CAM valid bits.
  - round-robin pointer rr_ptr (ADDR_LEFT+1 bits).
  - captured tag and data registers.
  - flush counter.
- IDLE:
  - req_ready = !flush.
  - flush=1: go to FLUSH with counter=0. Flush wins over a same-cycle req_valid, which is not accepted.
  - Otherwise, req_valid && req_ready: capture req_tag, go to LOOK.
- LOOK and CMP:
  - cam_read=1 and cam_check_tag=captured tag in both states.
  - cam_found/cam_data are sampled at the end of CMP, which tolerates a one-cycle registered CAM.
  - Hit: latch cam_data, set rsp_hit=1, go to RESP.
  - Miss: go to MREQ.
- MREQ:
  - mem_req=1 and mem_tag=captured tag, held until mem_ack.
  - On mem_ack: latch mem_rdata, go to FILL.
- FILL: one cycle with cam_write_=0, cam_w_addr=victim, cam_wdata=latched data, cam_new_tag=captured tag, cam_new_valid=1. Then set vmap[victim], set rsp_hit=0, go to RESP.
- Victim selection:
  - If any vmap bit is 0, the victim is the lowest-index invalid entry.
  - Otherwise the victim is rr_ptr, and rr_ptr increments after the fill, wrapping WORDS-1 -> 0.
  - rr_ptr does not move on fills into invalid entries.
- RESP: rsp_valid=1 with rsp_data/rsp_hit stable until rsp_ready. On the rsp_ready cycle, go to IDLE.
- FLUSH:
  - Each cycle: cam_write_=0, cam_w_addr=counter, cam_new_valid=0, cam_new_tag=0, cam_wdata=0.
  - Runs WORDS cycles, counter 0..WORDS-1.
  - On the last cycle: clear vmap, set rr_ptr=0, go to IDLE.
- flush asserted in any state other than IDLE is ignored.
- mem_ack outside MREQ is ignored.
- cam_write_=1 in every state except FILL and FLUSH.

## Timing
- Reset (async assert, sync-clean deassert):
  - State IDLE; vmap=0; rr_ptr=0.
  - Outputs: rsp_valid=0, rsp_data=0, rsp_hit=0, busy=0, cam_read=0, cam_write_=1, mem_req=0, all address/data/tag outputs 0.
  - req_ready=1 when flush=0.
- Reset asserted mid-operation aborts any request, fill or flush immediately, with no further CAM write.
- Hit latency: accept at cycle 0, LOOK at 1, CMP at 2, rsp_valid at 3.
- Miss latency: mem_req rises at cycle 3. With mem_ack at cycle k, FILL is at k+1 and rsp_valid at k+2.
- Flush occupies exactly WORDS cycles; req_ready=1 again on the following cycle.
- At most one request is outstanding; req_ready=0 whenever state != IDLE.

## Test plan
- Reset then idle: cam_write_=1, req_ready=1, rsp_valid=0, vmap=0.
- Miss on empty cache:
  - Stimulus: req_tag=0x3C, cam_found=0, mem_ack 4 cycles after mem_req with mem_rdata=0xA5.
  - Response: one write cycle with w_addr=0, tag 0x3C, data 0xA5, valid=1; then rsp_data=0xA5, rsp_hit=0.
- Hit:
  - Stimulus: req_tag=0x3C with cam_found=1, cam_data=0xA5.
  - Response: rsp_valid at cycle 3 with rsp_hit=1, rsp_data=0xA5; mem_req never asserted.
- Full-cache replacement:
  - Stimulus: 8 distinct misses, then 3 more misses.
  - Response: fills at addresses 0..7, then 0, 1, 2 (rr_ptr wrap).
- Flush with simultaneous req_valid:
  - Response: 8 consecutive writes with new_valid=0 at addresses 0..7; request not accepted until after the flush.
  - A following miss then fills address 0.
- Backpressure and reset mid-operation:
  - Hold rsp_ready=0 for 5 cycles: rsp_data/rsp_hit stay stable.
  - Assert rst_ during MREQ: mem_req drops immediately and no CAM write occurs.
